load_store_unit: RTL and testbench

- Initiator side of the data-memory load/store interface. Sits between the core's execute stage and dataMemory.
- Accepts load/store requests through a valid/ready handshake and buffers them in a small in-order queue.
- Sequences each request onto the memory's read/write/address/value lines, holding it for a configurable number of cycles.
- Returns load data to the core through a second valid/ready handshake.

---
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store initiator between the execute stage and data memory: an in-order
// request queue, a memory sequencer holding each access for WAIT_CYCLES+1 cycles, and a load-response port.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                  _CLK,
  input  logic                  _RST_N,
  input  logic                  _reqValid,
  output logic                  reqReady,
  input  logic                  _reqWrite,
  input  logic [DATA_WIDTH-1:0] _reqAddress,
  input  logic [DATA_WIDTH-1:0] _reqData,
  output logic                  rspValid,
  output logic [DATA_WIDTH-1:0] rspData,
  input  logic                  _rspReady,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [DATA_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  input  logic [DATA_WIDTH-1:0] _memReadData,
  output logic                  busy
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WAIT_W = 4;
  localparam logic        STROBE_ON_ENTRY = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  op_write;

  logic                  fifo_write [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic                  push;
  logic                  pop;

  // Acceptance depends on the registered count only, so a full queue never takes a same-cycle slot.
  assign reqReady = _RST_N && (count < CNT_W'(FIFO_DEPTH));
  assign push     = _reqValid && reqReady;
  assign pop      = (state == ACCESS) && (wait_cnt == '0);
  assign busy     = (count != '0) || (state != IDLE);

  always_ff @(posedge _CLK) begin
    if (push) begin
      fifo_write[wr_ptr] <= _reqWrite;
      fifo_addr[wr_ptr]  <= _reqAddress;
      fifo_data[wr_ptr]  <= _reqData;
    end
  end

  // The head stays queued until its access completes, so count covers the in-flight request.
  always_ff @(posedge _CLK or negedge _RST_N) begin
    if (!_RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge _CLK or negedge _RST_N) begin
    if (!_RST_N) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      op_write     <= 1'b0;
      memRead      <= 1'b0;
      memWrite     <= 1'b0;
      memAddress   <= '0;
      memWriteData <= '0;
      rspValid     <= 1'b0;
      rspData      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            op_write     <= fifo_write[rd_ptr];
            memAddress   <= fifo_addr[rd_ptr];
            memWriteData <= fifo_write[rd_ptr] ? fifo_data[rd_ptr] : '0;
            memRead      <= !fifo_write[rd_ptr];
            memWrite     <= fifo_write[rd_ptr] && STROBE_ON_ENTRY;
            wait_cnt     <= WAIT_W'(WAIT_CYCLES);
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
            // Store strobe occupies only the last ACCESS cycle.
            if (op_write && (wait_cnt == WAIT_W'(1))) memWrite <= 1'b1;
          end else begin
            memRead      <= 1'b0;
            memWrite     <= 1'b0;
            memAddress   <= '0;
            memWriteData <= '0;
            if (op_write) begin
              state <= IDLE;
            end else begin
              rspData  <= _memReadData;
              rspValid <= 1'b1;
              state    <= RESP;
            end
          end
        end
        RESP: begin
          if (_rspReady) begin
            rspValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: three instances (WAIT_CYCLES 1, 0, 3) each driving
// its own memory model; scenario tasks compare against hand-computed values.
module tb_load_store_unit;

  localparam int unsigned DW   = 8;
  localparam int          NDUT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_clear;
  logic          req_valid      [NDUT];
  logic          req_ready      [NDUT];
  logic          req_write      [NDUT];
  logic [DW-1:0] req_address    [NDUT];
  logic [DW-1:0] req_data       [NDUT];
  logic          rsp_valid      [NDUT];
  logic [DW-1:0] rsp_data       [NDUT];
  logic          rsp_ready      [NDUT];
  logic          mem_read       [NDUT];
  logic          mem_write      [NDUT];
  logic [DW-1:0] mem_address    [NDUT];
  logic [DW-1:0] mem_write_data [NDUT];
  logic [DW-1:0] mem_read_data  [NDUT];
  logic          busy           [NDUT];

  logic [DW-1:0] mem [NDUT][256];
  int            checks = 0;
  int            errors = 0;
  int            conflicts = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    load_store_unit #(
      .DATA_WIDTH (DW),
      .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3)),
      .FIFO_DEPTH (2)
    ) u_dut (
      ._CLK        (clk),
      ._RST_N      (rst_n),
      ._reqValid   (req_valid[g]),
      .reqReady    (req_ready[g]),
      ._reqWrite   (req_write[g]),
      ._reqAddress (req_address[g]),
      ._reqData    (req_data[g]),
      .rspValid    (rsp_valid[g]),
      .rspData     (rsp_data[g]),
      ._rspReady   (rsp_ready[g]),
      .memRead     (mem_read[g]),
      .memWrite    (mem_write[g]),
      .memAddress  (mem_address[g]),
      .memWriteData(mem_write_data[g]),
      ._memReadData(mem_read_data[g]),
      .busy        (busy[g])
    );
    assign mem_read_data[g] = mem[g][mem_address[g]];
  end

  // Data memory model: combinational read, write on the clock edge.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int k = 0; k < NDUT; k++)
        for (int a = 0; a < 256; a++) mem[k][a] <= '0;
    end else begin
      for (int k = 0; k < NDUT; k++)
        if (mem_write[k]) mem[k][mem_address[k]] <= mem_write_data[k];
    end
  end

  always @(negedge clk) begin
    int s;
    s = 0;
    for (int k = 0; k < NDUT; k++) if (mem_read[k] && mem_write[k]) s++;
    conflicts <= conflicts + s;
  end

  task automatic issue(input int k, input logic wr, input logic [DW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    req_valid[k] = 1'b1; req_write[k] = wr; req_address[k] = a; req_data[k] = d;
    while (!req_ready[k] && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (!req_ready[k]) begin
      errors++;
      $display("FAIL issue_timeout dut%0d addr %h: reqReady got %b exp 1", k, a, req_ready[k]);
    end else begin
      @(posedge clk); #1;
    end
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while ((busy[k] || rsp_valid[k]) && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (busy[k] || rsp_valid[k]) begin
      errors++;
      $display("FAIL idle_timeout dut%0d: busy got %b exp 0", k, busy[k]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_clear = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      req_valid[k] = 1'b1; req_write[k] = 1'b1; req_address[k] = 8'h55; req_data[k] = 8'h66;
      rsp_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if ({rsp_valid[k], mem_read[k], mem_write[k], busy[k], req_ready[k]} !== 5'b0 ||
          mem_address[k] !== '0 || rsp_data[k] !== '0) begin
        errors++;
        $display("FAIL reset_hold dut%0d: {rspV,rd,wr,busy,rdy} got %b exp 00000",
                 k, {rsp_valid[k], mem_read[k], mem_write[k], busy[k], req_ready[k]});
      end
      req_valid[k] = 1'b0;
    end
    mem_clear = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (req_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_release dut%0d: ready/busy got %b%b exp 10", k, req_ready[k], busy[k]);
      end
    end
  endtask

  task automatic test_store_load();
    int wcount, wn, lat;
    logic [DW-1:0] wa, wd;
    wcount = 0; wn = 0; wa = '0; wd = '0; lat = 0;
    issue(0, 1'b1, 8'h10, 8'hA5);
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      if (mem_write[0]) begin wcount++; wn = n; wa = mem_address[0]; wd = mem_write_data[0]; end
    end
    checks++;
    if (wcount != 1 || wn != 2 || wa !== 8'h10 || wd !== 8'hA5) begin
      errors++;
      $display("FAIL store_strobe: count %0d cycle %0d addr %h data %h exp 1 2 10 a5", wcount, wn, wa, wd);
    end
    checks++;
    if (mem[0][8'h10] !== 8'hA5) begin
      errors++;
      $display("FAIL store_landed: mem got %h exp a5", mem[0][8'h10]);
    end
    issue(0, 1'b0, 8'h10, 8'h00);
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (rsp_valid[0]) lat = n;
    end
    checks++;
    if (lat != 3 || rsp_data[0] !== 8'hA5) begin
      errors++;
      $display("FAIL load_latency: edges %0d data %h exp 3 a5", lat, rsp_data[0]);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    checks++;
    if (rsp_valid[0] !== 1'b0 || rsp_data[0] !== 8'hA5 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rsp_handshake: valid %b data %h busy %b exp 0 a5 0", rsp_valid[0], rsp_data[0], busy[0]);
    end
  endtask

  task automatic test_queue_full();
    logic [DW-1:0] got [4];
    logic [DW-1:0] want;
    int nr, acc_at, blocked;
    for (int i = 1; i <= 4; i++) issue(0, 1'b1, 8'(i), 8'(i * 17));
    wait_idle(0);
    rsp_ready[0] = 1'b0;
    for (int i = 1; i <= 3; i++) issue(0, 1'b0, 8'(i), 8'h00);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_address[0] = 8'h04;
    blocked = 1;
    for (int n = 0; n < 5; n++) begin
      if (req_ready[0]) blocked = 0;
      @(posedge clk); #1;
    end
    checks++;
    if (blocked != 1 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL queue_full_block: blocked %0d busy %b exp 1 1", blocked, busy[0]);
    end
    checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 8'h11) begin
      errors++;
      $display("FAIL backpressure_hold: valid %b data %h exp 1 11", rsp_valid[0], rsp_data[0]);
    end
    rsp_ready[0] = 1'b1;
    nr = 0; acc_at = -1;
    for (int cyc = 0; cyc < 100 && nr < 4; cyc++) begin
      logic a_now;
      a_now = req_valid[0] && req_ready[0];
      if (rsp_valid[0]) begin got[nr] = rsp_data[0]; nr++; end
      if (a_now) acc_at = nr;
      @(posedge clk); #1;
      if (a_now) req_valid[0] = 1'b0;
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b0;
    checks++;
    if (nr != 4 || acc_at < 1) begin
      errors++;
      $display("FAIL queue_drain: responses %0d accepted_after %0d exp 4 >=1", nr, acc_at);
    end
    for (int i = 0; i < nr; i++) begin
      want = 8'((i + 1) * 17);
      checks++;
      if (got[i] !== want) begin
        errors++;
        $display("FAIL queue_order[%0d]: data %h exp %h", i, got[i], want);
      end
    end
    wait_idle(0);
  endtask

  task automatic test_latency(input int k, input int w);
    int wcount, wn, acnt, rcnt, lat;
    wcount = 0; wn = 0; acnt = 0; rcnt = 0; lat = 0;
    issue(k, 1'b1, 8'h20, 8'h5C);
    for (int n = 1; n <= w + 6; n++) begin
      @(posedge clk); #1;
      if (mem_write[k]) begin wcount++; wn = n; end
      if (mem_address[k] === 8'h20 && mem_write_data[k] === 8'h5C) acnt++;
    end
    checks++;
    if (wcount != 1 || wn != w + 1 || acnt != w + 1) begin
      errors++;
      $display("FAIL store_window dut%0d: pulses %0d at %0d window %0d exp 1 %0d %0d",
               k, wcount, wn, acnt, w + 1, w + 1);
    end
    checks++;
    if (mem[k][8'h20] !== 8'h5C) begin
      errors++;
      $display("FAIL store_landed dut%0d: mem got %h exp 5c", k, mem[k][8'h20]);
    end
    issue(k, 1'b0, 8'h20, 8'h00);
    for (int n = 1; n <= w + 10 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (rsp_valid[k]) lat = n;
      if (mem_read[k] && mem_address[k] === 8'h20) rcnt++;
    end
    checks++;
    if (lat != w + 2 || rcnt != w + 1 || rsp_data[k] !== 8'h5C) begin
      errors++;
      $display("FAIL load_window dut%0d: latency %0d reads %0d data %h exp %0d %0d 5c",
               k, lat, rcnt, rsp_data[k], w + 2, w + 1);
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
    wait_idle(k);
  endtask

  task automatic test_reset_mid_store();
    issue(0, 1'b0, 8'h10, 8'h00);
    issue(2, 1'b1, 8'h40, 8'h12);
    issue(2, 1'b1, 8'h41, 8'h34);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid[0] !== 1'b1 || mem_write[2] !== 1'b0 || busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort: rspV0 %b wr2 %b busy2 %b exp 1 0 1", rsp_valid[0], mem_write[2], busy[2]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid[0] !== 1'b0 || busy[2] !== 1'b0 || mem_write[2] !== 1'b0 || mem_address[2] !== '0) begin
      errors++;
      $display("FAIL async_abort: rspV0 %b busy2 %b wr2 %b addr2 %h exp 0 0 0 00",
               rsp_valid[0], busy[2], mem_write[2], mem_address[2]);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (mem[2][8'h40] !== 8'h00 || mem[2][8'h41] !== 8'h00) begin
      errors++;
      $display("FAIL aborted_store: mem40 %h mem41 %h exp 00 00", mem[2][8'h40], mem[2][8'h41]);
    end
    checks++;
    if (busy[2] !== 1'b0 || req_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL post_abort_idle: busy %b ready %b exp 0 1", busy[2], req_ready[2]);
    end
  endtask

  task automatic test_random();
    logic          op_w [20];
    logic [DW-1:0] op_a [20];
    logic [DW-1:0] op_d [20];
    logic [DW-1:0] ref_mem [8];
    logic [DW-1:0] exp_q [$];
    int            idx;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    for (int i = 0; i < 20; i++) begin
      op_w[i] = 1'($urandom_range(0, 1));
      op_a[i] = 8'(8'h80 + $urandom_range(0, 7));
      op_d[i] = 8'($urandom_range(0, 255));
      if (op_w[i]) ref_mem[op_a[i] - 8'h80] = op_d[i];
      else exp_q.push_back(ref_mem[op_a[i] - 8'h80]);
    end
    idx = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          issue(0, op_w[i], op_a[i], op_d[i]);
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int cyc = 0; cyc < 3000 && idx < exp_q.size(); cyc++) begin
          logic hs;
          rsp_ready[0] = 1'($urandom_range(0, 1));
          hs = rsp_valid[0] && rsp_ready[0];
          if (hs) begin
            checks++;
            if (rsp_data[0] !== exp_q[idx]) begin
              errors++;
              $display("FAIL random_load[%0d]: data %h exp %h", idx, rsp_data[0], exp_q[idx]);
            end
            idx++;
          end
          @(posedge clk); #1;
        end
        rsp_ready[0] = 1'b0;
      end
    join
    checks++;
    if (idx != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: loads %0d exp %0d", idx, exp_q.size());
    end
    wait_idle(0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[0][8'h80 + i] !== ref_mem[i]) begin
        errors++;
        $display("FAIL random_mem[%0d]: mem %h exp %h", i, mem[0][8'h80 + i], ref_mem[i]);
      end
    end
    checks++;
    if (conflicts != 0) begin
      errors++;
      $display("FAIL rd_wr_overlap: cycles %0d exp 0", conflicts);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mem_clear = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_address[k] = '0; req_data[k] = '0;
      rsp_ready[k] = 1'b0;
    end
    test_reset();
    test_store_load();
    test_queue_full();
    test_latency(1, 0);
    test_latency(2, 3);
    test_reset_mid_store();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
